// File: rtl/matrix_inverse_pkg.sv
// +----------------------------------------------------------------------------+
// | matrix_inverse_pkg: FSM states and Q-format helpers for matrix_inverse_gj. |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

package matrix_inverse_pkg;

  typedef enum logic [3:0] {
    ST_IDLE   = 4'd0,
    ST_LOAD   = 4'd1,
    ST_SEARCH = 4'd2,
    ST_SWAP   = 4'd3,
    ST_RECIP  = 4'd4,
    ST_SCALE  = 4'd5,
    ST_ELIM   = 4'd6,
    ST_OUT    = 4'd7,
    ST_DONE   = 4'd8
  } state_t;

  function automatic longint q_one(input int frac);
    return longint'(1) <<< frac;
  endfunction

  function automatic longint sat_max(input int w);
    return (longint'(1) <<< (w - 1)) - longint'(1);
  endfunction

  function automatic longint sat_min(input int w);
    return -(longint'(1) <<< (w - 1));
  endfunction

  function automatic longint saturate(input longint v, input int w);
    if (v > sat_max(w)) return sat_max(w);
    if (v < sat_min(w)) return sat_min(w);
    return v;
  endfunction

  // LSB position of element (r,c) on the flattened matrix bus.
  function automatic int elem_lsb(input int n, input int w, input int r, input int c);
    return w * (r * n + c);
  endfunction

endpackage

`default_nettype wire

// File: rtl/matrix_inverse_gj_recip.sv
// +----------------------------------------------------------------------------+
// | recip_divider: restoring divider giving sign(p) * floor(2^(2*FRAC) / |p|). |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module recip_divider #(
  parameter int W    = 16,
  parameter int FRAC = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic signed [W-1:0]   pivot,
  output logic signed [2*FRAC+1:0] recip,
  output logic                  done
);
  localparam int QW   = 2 * FRAC + 1;
  localparam int CNTW = $clog2(QW + 1);

  logic            busy;
  logic            neg;
  logic [W-1:0]    divisor;
  logic [W-1:0]    rem;
  logic [QW-1:0]   quo;
  logic [CNTW-1:0] cnt;
  logic [W:0]      trial;
  logic [W-1:0]    diff;

  // The dividend is a single 1 at its MSB, so only the first shift brings in a 1.
  always_comb begin
    trial = {rem, (cnt == CNTW'(QW - 1))};
    diff  = trial[W-1:0] - divisor;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy    <= 1'b0;
      neg     <= 1'b0;
      divisor <= '0;
      rem     <= '0;
      quo     <= '0;
      cnt     <= '0;
    end else if (start) begin
      busy    <= 1'b1;
      neg     <= pivot[W-1];
      divisor <= pivot[W-1] ? $unsigned(-pivot) : $unsigned(pivot);
      rem     <= '0;
      quo     <= '0;
      cnt     <= CNTW'(QW - 1);
    end else if (busy) begin
      if (trial >= {1'b0, divisor}) begin
        rem <= diff;
        quo <= {quo[QW-2:0], 1'b1};
      end else begin
        rem <= trial[W-1:0];
        quo <= {quo[QW-2:0], 1'b0};
      end
      if (cnt == '0) busy <= 1'b0;
      else           cnt  <= cnt - CNTW'(1);
    end
  end

  // done marks the final iteration; recip is valid from the following cycle on.
  assign done  = busy && (cnt == '0);
  assign recip = neg ? -$signed({1'b0, quo}) : $signed({1'b0, quo});

endmodule

`default_nettype wire

// File: rtl/matrix_inverse_gj.sv
// +----------------------------------------------------------------------------+
// | matrix_inverse_gj: sequential Gauss-Jordan inverter, one element per cycle.|
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module matrix_inverse_gj
  import matrix_inverse_pkg::*;
#(
  parameter int N    = 3,
  parameter int W    = 16,
  parameter int FRAC = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [W*N*N-1:0] matrix_in,
  output logic             busy,
  output logic             done,
  output logic             singular,
  output logic             overflow,
  output logic [W*N*N-1:0] matrix_out
);
  localparam int     RW  = 2 * FRAC + 2;
  localparam int     CW  = $clog2(N);
  localparam int     JW  = $clog2(2 * N);
  localparam longint ONE = q_one(FRAC);

  state_t              state;
  logic signed [W-1:0] m [N][2*N];
  logic [CW-1:0]       col, row, piv_row, piv_idx;
  logic [JW-1:0]       j;
  logic signed [W-1:0] f_q, f_cur;
  logic                found, div_start, div_done, last_j, last_row;
  logic signed [RW-1:0] recip;
  logic signed [63:0]  scale_raw, elim_raw;
  logic signed [W-1:0] scale_sat, elim_sat;
  logic                scale_ovf, elim_ovf;

  recip_divider #(.W(W), .FRAC(FRAC)) u_recip (
    .clk   (clk),
    .rst   (rst),
    .start (div_start),
    .pivot (m[col][col]),
    .recip (recip),
    .done  (div_done)
  );

  always_comb begin
    found   = 1'b0;
    piv_idx = '0;
    // Descending scan so the lowest qualifying row wins.
    for (int r = N - 1; r >= 0; r--) begin
      if (r >= int'(col) && m[r][col] != '0) begin
        found   = 1'b1;
        piv_idx = CW'(r);
      end
    end
    f_cur     = (j == '0) ? m[row][col] : f_q;
    scale_raw = (64'(m[col][j]) * 64'(recip)) >>> FRAC;
    elim_raw  = 64'(m[row][j]) - ((64'(f_cur) * 64'(m[col][j])) >>> FRAC);
    scale_sat = W'(saturate(scale_raw, W));
    elim_sat  = W'(saturate(elim_raw, W));
    scale_ovf = (64'(scale_sat) != scale_raw);
    elim_ovf  = (64'(elim_sat) != elim_raw);
    last_j    = (j == JW'(2 * N - 1));
    last_row  = (int'(row) == N - 1) || (int'(row) == N - 2 && int'(col) == N - 1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      singular   <= 1'b0;
      overflow   <= 1'b0;
      matrix_out <= '0;
      col        <= '0;
      row        <= '0;
      piv_row    <= '0;
      j          <= '0;
      f_q        <= '0;
      div_start  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state    <= ST_LOAD;
            busy     <= 1'b1;
            done     <= 1'b0;
            singular <= 1'b0;
          end
        end
        ST_LOAD: begin
          for (int r = 0; r < N; r++) begin
            for (int k = 0; k < N; k++) begin
              m[r][k]     <= matrix_in[elem_lsb(N, W, r, k) +: W];
              m[r][N + k] <= (r == k) ? W'(ONE) : '0;
            end
          end
          overflow <= 1'b0;
          col      <= '0;
          state    <= ST_SEARCH;
        end
        ST_SEARCH: begin
          if (found) begin
            piv_row <= piv_idx;
            state   <= ST_SWAP;
          end else begin
            singular   <= 1'b1;
            matrix_out <= '0;
            done       <= 1'b1;
            busy       <= 1'b0;
            state      <= ST_DONE;
          end
        end
        ST_SWAP: begin
          for (int k = 0; k < 2 * N; k++) begin
            m[col][k]     <= m[piv_row][k];
            m[piv_row][k] <= m[col][k];
          end
          div_start <= 1'b1;
          state     <= ST_RECIP;
        end
        ST_RECIP: begin
          div_start <= 1'b0;
          if (div_done) begin
            j     <= '0;
            state <= ST_SCALE;
          end
        end
        ST_SCALE: begin
          m[col][j] <= scale_sat;
          if (scale_ovf) overflow <= 1'b1;
          if (last_j) begin
            j     <= '0;
            row   <= (col == '0) ? CW'(1) : '0;
            state <= ST_ELIM;
          end else begin
            j <= j + JW'(1);
          end
        end
        ST_ELIM: begin
          m[row][j] <= elim_sat;
          if (elim_ovf) overflow <= 1'b1;
          if (j == '0) f_q <= m[row][col];
          if (last_j) begin
            j <= '0;
            if (last_row) begin
              if (int'(col) == N - 1) begin
                state <= ST_OUT;
              end else begin
                col   <= col + CW'(1);
                state <= ST_SEARCH;
              end
            end else begin
              row <= (row + CW'(1) == col) ? row + CW'(2) : row + CW'(1);
            end
          end else begin
            j <= j + JW'(1);
          end
        end
        ST_OUT: begin
          for (int r = 0; r < N; r++) begin
            for (int k = 0; k < N; k++) begin
              matrix_out[elem_lsb(N, W, r, k) +: W] <= m[r][N + k];
            end
          end
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= ST_DONE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire
